mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- HI/LO multiply-divide responder serving the execute stage's Start/Busy/HILO interface.
- Accepts a one-cycle Start with an operation and operands, holds Busy for a fixed multi-cycle latency, then commits the result to the HI/LO registers.
- Also serves mthi/mtlo writes (single-cycle, no Busy) and the mfhi/mflo read path back into the execute result mux.

Parameters:
- MULT_CYCLES, 5, number of cycles Busy stays high for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, number of cycles Busy stays high for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle request qualifier for MDOp = mult/multu/div/divu.
- MDOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- A  input  32  rs operand (forwarded value).
- B  input  32  rt operand (forwarded value).
- HiLoSel  input  1  read select for HILO: 1 = HI, 0 = LO.
- Busy  output  1  registered; high while a mult/div is in flight.
- HILO  output  32  combinational read of the currently committed HI or LO, per HiLoSel.

Behaviour:
- Reset:
  - HI = 0, LO = 0, Busy = 0, counter = 0, state = IDLE.
  - Reset mid-operation aborts it: no commit; Busy is low in the cycle after the reset edge.
- States:
  - IDLE: if Start = 1 and MDOp is 1..4 at edge T0, latch A, B and the op, load counter = MULT_CYCLES or DIV_CYCLES, and go to RUN.
  - RUN: decrement counter each edge. At the edge where counter = 1, commit the pending result to HI/LO and return to IDLE.
- Timing:
  - Busy = 1 for exactly N cycles (T0+1 .. T0+N).
  - New HI/LO is visible on HILO from cycle T0+N+1, the same cycle Busy falls.
  - HILO never shows partial or new values while Busy = 1; it keeps returning the old committed values.
- mthi/mtlo:
  - In IDLE, MDOp = 5 (or 6) writes A into HI (or LO) at that edge, regardless of Start; Busy stays 0.
  - HILO reflects the written value in the next cycle.
  - No same-cycle bypass: the read is of the committed register.
- Requests while Busy = 1:
  - Start and mthi/mtlo are ignored; the in-flight operation completes unaffected.
  - The hazard unit must stall these requests. The block does not queue them.
- MDOp = 1..4 with Start = 0: no action.
- Start = 1 with MDOp = 0, 5, 6 or 7: no Busy. mthi/mtlo still write, as above.
- Arithmetic:
  - mult: 64-bit signed product of A and B; HI = [63:32], LO = [31:0].
  - multu: the same, unsigned.
  - div: LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend (A).
  - divu: unsigned quotient and remainder.
  - div of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Divide by zero (B = 0, div or divu):
  - Busy still runs for DIV_CYCLES.
  - HI and LO stay unchanged at commit.
- Operands are sampled only at T0; later changes on A/B have no effect.
- Implementation freedom: the result may be computed at T0 and held, or iteratively. Only the cycle-level observable behaviour above is specified.

Test Plan:
- Reset, then mult with A = 0xFFFFFFFE (-2), B = 3, Start pulse at T0 -> Busy high T0+1..T0+5; at T0+6, HI = 0xFFFFFFFF, LO = 0xFFFFFFFA, Busy = 0.
- multu with A = 0xFFFFFFFF, B = 0xFFFFFFFF -> after 5 Busy cycles, HI = 0xFFFFFFFE, LO = 0x00000001. HILO returns the old values during Busy.
- div with A = -7 (0xFFFFFFF9), B = 2 -> Busy for 10 cycles, then LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1). divu with the same operands -> LO = 0x7FFFFFFC, HI = 1.
- mthi with A = 0x12345678, then mtlo with A = 0x9ABCDEF0 -> next cycle HILO(HiLoSel=1) = 0x12345678 and HILO(HiLoSel=0) = 0x9ABCDEF0, Busy never asserted. Then divu by B = 0 -> 10 Busy cycles, HI/LO unchanged.
- During a div, at cycle T0+3 pulse Start with mult and, separately, mtlo with A = 0xDEADBEEF -> both ignored; Busy falls at T0+11 with only the div result committed.
- Start a mult, assert reset at T0+2 -> Busy = 0 from T0+3, HI = LO = 0. A new mult right after reset completes normally in 5 cycles.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Start/Busy/HILO link between the execute stage (master) and the HI/LO
// multiply-divide unit (slave).
interface mult_div_unit_if;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        HiLoSel;
    logic        Busy;
    logic [31:0] HILO;

    modport master (
        output Start,
        output MDOp,
        output A,
        output B,
        output HiLoSel,
        input  Busy,
        input  HILO
    );

    modport slave (
        input  Start,
        input  MDOp,
        input  A,
        input  B,
        input  HiLoSel,
        output Busy,
        output HILO
    );
endinterface

// File: rtl/mult_div_unit.sv
// HI/LO multiply-divide unit: fixed-latency mult/div with Busy, plus
// single-cycle mthi/mtlo writes and a combinational mfhi/mflo read port.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic            clk,
    input logic            reset,
    mult_div_unit_if.slave md
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    md_op_t      op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    md_op_t      op_in;
    logic        start_ok;
    logic        start_is_mult;

    logic [63:0] prod_signed;
    logic [63:0] prod_unsigned;
    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] dividend_mag;
    logic [31:0] divisor_mag;
    logic [31:0] divisor_safe;
    logic [31:0] quot_mag;
    logic [31:0] rem_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign op_in         = md_op_t'(md.MDOp);
    assign start_ok      = md.Start && (op_in == OP_MULT || op_in == OP_MULTU ||
                                        op_in == OP_DIV  || op_in == OP_DIVU);
    assign start_is_mult = (op_in == OP_MULT) || (op_in == OP_MULTU);

    // Result is formed from the operands latched at start; it only has to
    // settle by the final Busy cycle, when it is committed.
    assign prod_signed   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_unsigned = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide goes through magnitudes so 0x80000000 / -1 wraps cleanly.
    assign div_signed   = (op_q == OP_DIV);
    assign a_neg        = div_signed & a_q[31];
    assign b_neg        = div_signed & b_q[31];
    assign dividend_mag = a_neg ? (~a_q + 32'd1) : a_q;
    assign divisor_mag  = b_neg ? (~b_q + 32'd1) : b_q;
    assign divisor_safe = (b_q == 32'd0) ? 32'd1 : divisor_mag;
    assign quot_mag     = dividend_mag / divisor_safe;
    assign rem_mag      = dividend_mag % divisor_safe;
    assign quot         = (a_neg ^ b_neg) ? (~quot_mag + 32'd1) : quot_mag;
    assign rem          = a_neg ? (~rem_mag + 32'd1) : rem_mag;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            op_q    <= OP_NONE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start_ok) begin
                    op_d    = op_in;
                    a_d     = md.A;
                    b_d     = md.B;
                    cnt_d   = start_is_mult ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else if (op_in == OP_MTHI) begin
                    hi_d = md.A;
                end else if (op_in == OP_MTLO) begin
                    lo_d = md.A;
                end
            end

            RUN: begin
                // Requests arriving here are dropped; the hazard unit stalls them.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    case (op_q)
                        OP_MULT: begin
                            hi_d = prod_signed[63:32];
                            lo_d = prod_signed[31:0];
                        end
                        OP_MULTU: begin
                            hi_d = prod_unsigned[63:32];
                            lo_d = prod_unsigned[31:0];
                        end
                        OP_DIV, OP_DIVU: begin
                            if (b_q != 32'd0) begin
                                hi_d = rem;
                                lo_d = quot;
                            end
                        end
                        default: begin
                            hi_d = hi_q;
                            lo_d = lo_q;
                        end
                    endcase
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign md.Busy = busy_q;
    assign md.HILO = md.HiLoSel ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table of mult/div results plus
// hand-written sequences for mthi/mtlo, divide-by-zero, busy hazards and reset abort.
module tb_mult_div_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    mult_div_unit_if md_bus ();

    mult_div_unit #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .md   (md_bus.slave)
    );

    always #5 clk = ~clk;

    int          check_count = 0;
    int          pass_count  = 0;
    logic [31:0] model_hi    = 32'd0;
    logic [31:0] model_lo    = 32'd0;
    vec_t        vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
        md_bus.Start = start;
        md_bus.MDOp  = op;
        md_bus.A     = a;
        md_bus.B     = b;
    endtask

    task automatic readHiLo(output logic [31:0] hi, output logic [31:0] lo);
        md_bus.HiLoSel = 1'b1;
        #1;
        hi = md_bus.HILO;
        md_bus.HiLoSel = 1'b0;
        #1;
        lo = md_bus.HILO;
    endtask

    // Issue one mult/div, count Busy cycles (bounded) and check the commit.
    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int n,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int          busy_cycles;
        logic [31:0] h, l;
        @(negedge clk);
        applyStimulus(1'b1, op, a, b);
        @(negedge clk);
        applyStimulus(1'b0, OP_NONE, ~a, ~b);
        busy_cycles = 0;
        while (md_bus.Busy === 1'b1 && busy_cycles < 20) begin
            if (busy_cycles == 0 || busy_cycles == n - 1) begin
                readHiLo(h, l);
                checkOutput({tag, "_hold_hi"}, h, model_hi);
                checkOutput({tag, "_hold_lo"}, l, model_lo);
            end
            busy_cycles++;
            @(negedge clk);
        end
        checkOutput({tag, "_busy_len"}, 32'(busy_cycles), 32'(n));
        readHiLo(h, l);
        checkOutput({tag, "_hi"}, h, exp_hi);
        checkOutput({tag, "_lo"}, l, exp_lo);
        model_hi = exp_hi;
        model_lo = exp_lo;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] h, l;
        int          busy_cycles;

        vecs[0] = '{OP_MULT,  32'hFFFFFFFE, 32'h00000003, MULT_N, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MULT_N, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, DIV_N,  32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{OP_DIVU,  32'hFFFFFFF9, 32'h00000002, DIV_N,  32'h00000001, 32'h7FFFFFFC};
        vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, DIV_N,  32'h00000000, 32'h80000000};
        vecs[5] = '{OP_MULT,  32'h80000000, 32'h80000000, MULT_N, 32'h40000000, 32'h00000000};
        vecs[6] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, DIV_N,  32'h00000001, 32'hFFFFFFFD};
        vecs[7] = '{OP_MULTU, 32'h00010000, 32'h00010000, MULT_N, 32'h00000001, 32'h00000000};

        reset          = 1'b1;
        md_bus.HiLoSel = 1'b0;
        applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 32'(md_bus.Busy), 32'd0);
        readHiLo(h, l);
        checkOutput("reset_hi", h, 32'd0);
        checkOutput("reset_lo", l, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].cycles, vecs[i].hi, vecs[i].lo);
        end

        // Ops without Start, and Start with non-arithmetic ops, never raise Busy.
        @(negedge clk);
        applyStimulus(1'b0, OP_MULT, 32'd5, 32'd5);
        @(negedge clk);
        checkOutput("nostart_busy", 32'(md_bus.Busy), 32'd0);
        applyStimulus(1'b1, OP_RSVD, 32'd5, 32'd5);
        @(negedge clk);
        checkOutput("rsvd_busy", 32'(md_bus.Busy), 32'd0);
        applyStimulus(1'b1, OP_NONE, 32'd5, 32'd5);
        @(negedge clk);
        checkOutput("none_busy", 32'(md_bus.Busy), 32'd0);
        applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0);
        readHiLo(h, l);
        checkOutput("noaction_hi", h, model_hi);
        checkOutput("noaction_lo", l, model_lo);

        // mthi then mtlo (the latter with Start high, which must not matter).
        @(negedge clk);
        applyStimulus(1'b0, OP_MTHI, 32'h12345678, 32'd0);
        @(negedge clk);
        applyStimulus(1'b1, OP_MTLO, 32'h9ABCDEF0, 32'd0);
        checkOutput("mthi_busy", 32'(md_bus.Busy), 32'd0);
        readHiLo(h, l);
        checkOutput("mthi_hi", h, 32'h12345678);
        @(negedge clk);
        applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0);
        checkOutput("mtlo_busy", 32'(md_bus.Busy), 32'd0);
        readHiLo(h, l);
        checkOutput("mtlo_hi", h, 32'h12345678);
        checkOutput("mtlo_lo", l, 32'h9ABCDEF0);
        model_hi = 32'h12345678;
        model_lo = 32'h9ABCDEF0;

        runOp("divu_by0", OP_DIVU, 32'h00000064, 32'd0, DIV_N, model_hi, model_lo);
        runOp("div_by0",  OP_DIV,  32'hFFFFFF9C, 32'd0, DIV_N, model_hi, model_lo);

        // div 100/7 with a mult Start at T0+3 and an mtlo at T0+4, both dropped.
        @(negedge clk);
        applyStimulus(1'b1, OP_DIV, 32'd100, 32'd7);
        @(negedge clk);
        applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0);
        checkOutput("hazard_busy_t1", 32'(md_bus.Busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        applyStimulus(1'b1, OP_MULT, 32'd3, 32'd3);
        @(negedge clk);
        applyStimulus(1'b0, OP_MTLO, 32'hDEADBEEF, 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0);
        readHiLo(h, l);
        checkOutput("hazard_hold_hi", h, model_hi);
        checkOutput("hazard_hold_lo", l, model_lo);
        busy_cycles = 4;
        while (md_bus.Busy === 1'b1 && busy_cycles < 20) begin
            busy_cycles++;
            @(negedge clk);
        end
        checkOutput("hazard_busy_len", 32'(busy_cycles), 32'(DIV_N));
        readHiLo(h, l);
        checkOutput("hazard_hi", h, 32'd2);
        checkOutput("hazard_lo", l, 32'd14);
        @(negedge clk);
        checkOutput("hazard_no_restart", 32'(md_bus.Busy), 32'd0);
        model_hi = 32'd2;
        model_lo = 32'd14;

        // Reset at T0+2 aborts an in-flight mult and clears HI/LO.
        @(negedge clk);
        applyStimulus(1'b1, OP_MULT, 32'd3, 32'd5);
        @(negedge clk);
        applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0);
        checkOutput("abort_busy_t1", 32'(md_bus.Busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_busy_t3", 32'(md_bus.Busy), 32'd0);
        readHiLo(h, l);
        checkOutput("abort_hi", h, 32'd0);
        checkOutput("abort_lo", l, 32'd0);
        model_hi = 32'd0;
        model_lo = 32'd0;
        repeat (6) @(negedge clk);
        readHiLo(h, l);
        checkOutput("abort_no_commit_lo", l, 32'd0);

        runOp("post_reset_mult", OP_MULT, 32'd6, 32'd7, MULT_N, 32'd0, 32'd42);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
